vga_tile_renderer: RTL
======================

// Module: vga_tile_renderer
// PURPOSE
//  Pixel stage directly downstream of the VGA timing controller. Consumes posx/posy/blank_n/h_sync/v_sync,
//  looks up a 20x15 tile map (32x32-pixel tiles, 3-bit colour index each) and drives 8-bit RGB to the DAC.
//  Delays syncs/blank to match the 3-cycle pixel pipeline. Tile map is written by game/control logic
//  through a valid/ready port; writes are granted only during blanking.
// PARAMETERS
//  TILE_SHIFT  5    log2 tile edge in pixels (32)
//  MAP_W       20   tiles per row
//  MAP_H       15   tile rows; map depth = MAP_W*MAP_H = 300
// PORTS
//  clk          in   1   pixel clock (25 MHz), same clock as timing controller
//  rst          in   1   asynchronous, active-high reset
//  posx         in   10  pixel column from timing controller (0..639 while blank_n_in=1)
//  posy         in   10  pixel row (0..479 while blank_n_in=1)
//  blank_n_in   in   1   1 = active video
//  h_sync_in    in   1   horizontal sync, passed through
//  v_sync_in    in   1   vertical sync, active low, passed through
//  wr_valid     in   1   tile write request
//  wr_addr      in   9   tile index = row*MAP_W + col
//  wr_data      in   3   colour index
//  wr_ready     out  1   write accepted this cycle when wr_valid & wr_ready
//  wr_err       out  1   sticky: an accepted write had wr_addr >= 300
//  red,green,blue out 8  pixel colour to DAC
//  h_sync,v_sync,blank_n out 1  syncs/blank delayed 3 cycles
//  frame_cnt    out  8   frames rendered, wraps 255->0
// BEHAVIOUR
//  Reset: FSM=CLEAR, clear index=0, RGB=0, h_sync=0, v_sync=1, blank_n=0, wr_ready=0, wr_err=0, frame_cnt=0.
//  FSM CLEAR: one map entry written to 0 per cycle, idx 0..299; after idx 299 -> RUN (300 cycles).
//    In CLEAR: wr_ready=0, RGB=0; syncs/blank still pipelined normally.
//  FSM RUN: stays until rst. rst mid-frame or mid-clear restarts CLEAR from idx 0 immediately.
//  Pipeline (RUN): S1 reg tile addr = (posy>>5)*20 + (posx>>5) (range 0..299) and blank_n_in;
//    S2 map read (single port); S3 fixed palette -> RGB. Latency 3 cycles for RGB, h_sync, v_sync, blank_n.
//  RGB forced 0 whenever delayed blank_n=0.
//  Palette: 0 black 000000, 1 red FF0000, 2 green 00FF00, 3 blue 0000FF, 4 yellow FFFF00,
//    5 cyan 00FFFF, 6 magenta FF00FF, 7 white FFFFFF.
//  Map port arbitration: read when blank_n_in=1; otherwise write. wr_ready = RUN & ~blank_n_in (comb.).
//  Accepted write with wr_addr>=300: dropped, wr_err set, stays set until rst.
//  wr_valid while wr_ready=0: no effect; requester holds data (no buffering in this block).
//  frame_cnt increments on v_sync_in falling edge (registered edge detect, 1-cycle delay); 255 wraps to 0.
//  Write during blank immediately before a pixel reading same tile: new data visible (write precedes read).
// CONFIGURATION
//  GRID_LINES_EN defined: pixels with posx[4:0]==0 or posy[4:0]==0 in active video drawn white (FFFFFF),
//    overriding tile colour; same 3-cycle latency. Undefined: tile colour only, no grid logic.
// TESTING
//  1 rst pulse, free-run 300 cycles -> wr_ready=0 for cycles 0..299 after release, 1 from next blank.
//  2 write addr 21 data 1 in blank, then pixel (32,32) active -> red=FF,green=00,blue=00 exactly 3 clk later.
//  3 wr_valid with blank_n_in=1 -> wr_ready=0, map unchanged; write addr 300 in blank -> wr_err=1, no map change.
//  4 drive h_sync_in/v_sync_in/blank_n_in step patterns -> outputs identical, delayed 3 cycles; RGB=0 when blank.
//  5 256 v_sync_in falling edges -> frame_cnt returns to 0; rst mid-frame -> frame_cnt=0, FSM back in CLEAR.
//  6 GRID_LINES_EN build, all tiles 3 -> pixel (64,10) white, (65,10) blue; without macro both blue.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// Tile-map pixel stage: 20x15 map of 3-bit colour indices, 3-cycle pipeline to RGB with matched syncs/blank.
// Optional build macro GRID_LINES_EN overlays white grid lines on tile boundaries.
module vga_tile_renderer #(
    parameter int TILE_SHIFT = 5,
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] posx,
    input  logic [9:0] posy,
    input  logic       blank_n_in,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       wr_valid,
    input  logic [8:0] wr_addr,
    input  logic [2:0] wr_data,
    output logic       wr_ready,
    output logic       wr_err,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       h_sync,
    output logic       v_sync,
    output logic       blank_n,
    output logic [7:0] frame_cnt
);
    localparam int         DEPTH    = MAP_W * MAP_H;
    localparam logic [8:0] LAST_IDX = 9'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t      r_state;
    logic [8:0]  r_clr_idx;
    logic [8:0]  r_addr;
    logic [2:0]  r_tile;
    logic [2:0]  r_mem [0:DEPTH-1];
    logic [2:0]  r_blank_pipe;
    logic [2:0]  r_hs_pipe;
    logic [2:0]  r_vs_pipe;
    logic [23:0] r_rgb;
    logic        r_wr_err;
    logic        r_vs_prev;
    logic        r_vs_fall;
    logic [7:0]  r_frame_cnt;

    logic        w_clear;
    logic        w_wr_accept;
    logic        w_wr_oob;
    logic        w_mem_we;
    logic [8:0]  w_mem_addr;
    logic [2:0]  w_mem_wdata;
    logic [8:0]  w_tile_x;
    logic [8:0]  w_tile_y;
    logic [23:0] w_pix_rgb;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'h000000;
            3'd1:    c = 24'hFF0000;
            3'd2:    c = 24'h00FF00;
            3'd3:    c = 24'h0000FF;
            3'd4:    c = 24'hFFFF00;
            3'd5:    c = 24'h00FFFF;
            3'd6:    c = 24'hFF00FF;
            default: c = 24'hFFFFFF;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= 9'd0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_idx == LAST_IDX) begin
                        r_state   <= ST_RUN;
                        r_clr_idx <= 9'd0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 9'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Single map port: the clearing sweep or an accepted write wins, otherwise the pixel read.
    assign w_clear     = (r_state == ST_CLEAR);
    assign wr_ready    = (r_state == ST_RUN) & ~blank_n_in;
    assign w_wr_accept = wr_valid & wr_ready;
    assign w_wr_oob    = (wr_addr > LAST_IDX);
    assign w_mem_we    = w_clear | (w_wr_accept & ~w_wr_oob);
    assign w_mem_addr  = w_clear ? r_clr_idx : wr_addr;
    assign w_mem_wdata = w_clear ? 3'd0 : wr_data;

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_wdata;
        else
            r_tile <= r_mem[r_addr];
    end

    assign w_tile_x = 9'(posx >> TILE_SHIFT);
    assign w_tile_y = 9'(posy >> TILE_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= 9'd0;
            r_blank_pipe <= 3'b000;
            r_hs_pipe    <= 3'b000;
            r_vs_pipe    <= 3'b111;
            r_rgb        <= 24'h000000;
        end else begin
            r_addr       <= 9'(w_tile_y * 9'(MAP_W) + w_tile_x);
            r_blank_pipe <= {r_blank_pipe[1:0], blank_n_in};
            r_hs_pipe    <= {r_hs_pipe[1:0], h_sync_in};
            r_vs_pipe    <= {r_vs_pipe[1:0], v_sync_in};
            r_rgb        <= (!w_clear && r_blank_pipe[1]) ? w_pix_rgb : 24'h000000;
        end
    end

`ifdef GRID_LINES_EN
    logic [1:0] r_grid_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_grid_pipe <= 2'b00;
        else
            r_grid_pipe <= {r_grid_pipe[0],
                            (posx[TILE_SHIFT-1:0] == '0) || (posy[TILE_SHIFT-1:0] == '0)};
    end

    assign w_pix_rgb = r_grid_pipe[1] ? 24'hFFFFFF : palette(r_tile);
`else
    assign w_pix_rgb = palette(r_tile);
`endif

    // Falling edge of v_sync_in is registered before it bumps the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err    <= 1'b0;
            r_vs_prev   <= 1'b1;
            r_vs_fall   <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            if (w_wr_accept && w_wr_oob)
                r_wr_err <= 1'b1;
            r_vs_prev <= v_sync_in;
            r_vs_fall <= r_vs_prev & ~v_sync_in;
            if (r_vs_fall)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign wr_err    = r_wr_err;
    assign red       = r_rgb[23:16];
    assign green     = r_rgb[15:8];
    assign blue      = r_rgb[7:0];
    assign h_sync    = r_hs_pipe[2];
    assign v_sync    = r_vs_pipe[2];
    assign blank_n   = r_blank_pipe[2];
    assign frame_cnt = r_frame_cnt;

endmodule
